pwm_scan_ctrl: RTL and testbench
================================

Name: pwm_scan_ctrl

Overview:
- Frame sequencer for the PWM output array.
- Accepts a per-row stream of STAGE brightness words and shifts them into the channel data latches.
- Issues the hsync latch strobe, then drives the shared global PWM count for one full period.
- Steps the row select through ROWS rows, with a blanking cycle between rows. Sits between the pixel source and the latch/counter/PWM block array.

Parameters:
- DWIDTH, 8, brightness word width; one PWM period = 2^DWIDTH cycles.
- STAGE, 8, PWM channels per row (words shifted per row).
- ROWS, 4, rows scanned per frame; ROWS >= 1.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin one frame; sampled only in IDLE.
- stop  input  1  abort; return to IDLE at next edge.
- data_in  input  DWIDTH  brightness word from pixel source.
- data_valid  input  1  data_in valid.
- data_ready  output  1  controller accepts data_in this cycle.
- shift_en  output  1  shift one word into the latch chain.
- shift_data  output  DWIDTH  word being shifted.
- hsync  output  1  one-cycle latch strobe to channel latches.
- pwm_en  output  1  PWM outputs enabled (blank when 0).
- gcount  output  DWIDTH  global PWM count to all PWM blocks.
- row_sel  output  clog2(ROWS) (min 1)  active row index.
- busy  output  1  high in any state except IDLE.
- frame_done  output  1  one-cycle pulse after last row's RUN.

Behaviour:
- Reset: state=IDLE. All outputs 0, including row_sel and gcount. load_cnt=0.
- The one-cycle reset value dominates any input.
- States: IDLE, LOAD, LATCH, RUN, BLANK.
- IDLE, start=1: go to LOAD next cycle with row_sel=0 and load_cnt=0.
- LOAD: data_ready=1 combinationally, only while in LOAD.
  - Accept = data_valid & data_ready.
  - Per accept: the next cycle has shift_en=1 and shift_data=accepted word (registered, 1-cycle latency). load_cnt increments.
  - No accept: shift_en=0 next cycle. shift_data holds.
  - Accept with load_cnt==STAGE-1: go to LATCH. The final shift_en appears during the LATCH cycle.
- LATCH: lasts 2 cycles.
  - Cycle 1 carries the final shift.
  - Cycle 2 has hsync=1, so hsync always follows the last shift by exactly 1 cycle.
  - Then go to RUN with gcount=0.
- RUN: pwm_en=1. gcount increments by 1 each cycle, 0 through 2^DWIDTH-1, for exactly 2^DWIDTH cycles.
  - At the cycle where gcount==max, the next state is decided:
    - row_sel==ROWS-1: IDLE, with frame_done=1 for one cycle and gcount=0.
    - Otherwise: BLANK.
- BLANK: 1 cycle. pwm_en=0, gcount=0, row_sel increments. Then LOAD with load_cnt=0.
- pwm_en=0 in every state except RUN. hsync and shift_en are never high simultaneously.
- data_ready=0 outside LOAD. Source words offered then are not consumed.
- start while busy: ignored, with no queuing.
- stop=1 in any non-IDLE state: next cycle is IDLE.
  - All outputs cleared as at reset; frame_done is not pulsed.
  - Partial load is discarded; the latches keep previous contents because no hsync is issued.
- stop and start together in IDLE: stop wins, stay IDLE.
- ROWS=1: no BLANK; RUN goes straight to IDLE.
- gcount is exactly DWIDTH bits. Wrap from max is never observed because the state exits RUN.

Decomposition:
- Shared package pwm_pkg holds:
  - state enum: IDLE, LOAD, LATCH, RUN, BLANK;
  - localparam PERIOD = 2^DWIDTH;
  - row-index width function.
- One natural sub-module: pwm_period_cnt, the DWIDTH-bit counter with clear, enable and terminal-count flag. It drives gcount and the RUN exit.
- Everything else stays in the top FSM.

Test Plan (DWIDTH=4, STAGE=4, ROWS=2):
- Normal frame: start, then words 3,7,0,15 with valid always high.
  - shift_en high 4 consecutive cycles carrying 3,7,0,15.
  - hsync 1 cycle after the last shift.
  - 16 RUN cycles, gcount 0..15, pwm_en=1.
  - 1 BLANK cycle, row_sel 0->1, second row identical.
  - frame_done pulses once, busy falls the same cycle.
- Throttled source: data_valid toggles 1,0,1,0,...
  - Exactly 4 shifts, gaps matching the valid gaps, words in order.
  - hsync still exactly 1 cycle after the 4th shift.
- Stop mid-RUN: stop at gcount=9, row 0.
  - Next cycle IDLE; pwm_en=0, gcount=0, row_sel=0, busy=0.
  - No frame_done, no further hsync.
- Stop mid-LOAD after 2 words: IDLE next cycle, no hsync.
  - A new start then reloads 4 fresh words from row 0.
- Start while busy: pulse start during row-1 RUN. No effect; single frame_done, then IDLE.
- Reset mid-LATCH: rst during the hsync cycle clears all outputs next edge. ROWS=1 build: RUN to IDLE with no BLANK.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared state encoding, default sizing and helpers for the PWM scan controller.
package pwm_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        LATCH = 3'd2,
        RUN   = 3'd3,
        BLANK = 3'd4
    } scan_state_e;

    localparam int DWIDTH_DEF = 8;
    localparam int STAGE_DEF  = 8;
    localparam int ROWS_DEF   = 4;
    localparam int PERIOD     = 1 << DWIDTH_DEF;

    // Index width that stays at least one bit wide when only one entry exists.
    function automatic int idxWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pwm_period_cnt.sv
// Global PWM period counter: synchronous clear beats enable, tc flags the last count.
module pwm_period_cnt #(
    parameter int DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              en_i,
    output logic [DWIDTH-1:0] count_o,
    output logic              tc_o
);

    logic [DWIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + DWIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = en_i && (count_q == '1);

endmodule

// File: rtl/pwm_scan_ctrl.sv
// Frame sequencer: loads a row of brightness words, strobes the latches,
// runs one PWM period per row and steps the row select with blanking between rows.
module pwm_scan_ctrl
    import pwm_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int STAGE  = STAGE_DEF,
    parameter int ROWS   = ROWS_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      stop_i,
    input  logic [DWIDTH-1:0]         data_in_i,
    input  logic                      data_valid_i,
    output logic                      data_ready_o,
    output logic                      shift_en_o,
    output logic [DWIDTH-1:0]         shift_data_o,
    output logic                      hsync_o,
    output logic                      pwm_en_o,
    output logic [DWIDTH-1:0]         gcount_o,
    output logic [idxWidth(ROWS)-1:0] row_sel_o,
    output logic                      busy_o,
    output logic                      frame_done_o
);

    localparam int RS_W = idxWidth(ROWS);
    localparam int LC_W = idxWidth(STAGE);

    scan_state_e       state_q, state_d;
    logic [LC_W-1:0]   loadCnt_q, loadCnt_d;
    logic              latchPh_q, latchPh_d;
    logic [RS_W-1:0]   rowSel_q, rowSel_d;
    logic              shiftEn_q, shiftEn_d;
    logic [DWIDTH-1:0] shiftData_q, shiftData_d;
    logic              frameDone_q, frameDone_d;

    logic              accept;
    logic              lastWord;
    logic              lastRow;
    logic              cntClear;
    logic              cntEn;
    logic              cntTc;
    logic [DWIDTH-1:0] gcount;

    assign accept   = (state_q == LOAD) && data_valid_i;
    assign lastWord = (loadCnt_q == LC_W'(STAGE - 1));
    assign lastRow  = (rowSel_q == RS_W'(ROWS - 1));
    assign cntEn    = (state_q == RUN);
    // Holding the counter cleared outside RUN guarantees every row starts at zero.
    assign cntClear = stop_i || (state_q != RUN);

    pwm_period_cnt #(
        .DWIDTH (DWIDTH)
    ) u_period_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (cntClear),
        .en_i    (cntEn),
        .count_o (gcount),
        .tc_o    (cntTc)
    );

    always_comb begin
        state_d     = state_q;
        loadCnt_d   = loadCnt_q;
        latchPh_d   = 1'b0;
        rowSel_d    = rowSel_q;
        shiftEn_d   = 1'b0;
        shiftData_d = shiftData_q;
        frameDone_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = LOAD;
                    rowSel_d  = '0;
                    loadCnt_d = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    shiftEn_d   = 1'b1;
                    shiftData_d = data_in_i;
                    loadCnt_d   = loadCnt_q + LC_W'(1);
                    if (lastWord) begin
                        state_d   = LATCH;
                        loadCnt_d = '0;
                    end
                end
            end
            // First LATCH cycle carries the final shift; the second strobes hsync.
            LATCH: begin
                if (latchPh_q) begin
                    state_d = RUN;
                end else begin
                    latchPh_d = 1'b1;
                end
            end
            RUN: begin
                if (cntTc) begin
                    if (lastRow) begin
                        state_d     = IDLE;
                        rowSel_d    = '0;
                        frameDone_d = 1'b1;
                    end else begin
                        state_d  = BLANK;
                        rowSel_d = rowSel_q + RS_W'(1);
                    end
                end
            end
            BLANK: begin
                state_d   = LOAD;
                loadCnt_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort discards any partial row; no hsync means the latches keep old data.
        if (stop_i) begin
            state_d     = IDLE;
            loadCnt_d   = '0;
            latchPh_d   = 1'b0;
            rowSel_d    = '0;
            shiftEn_d   = 1'b0;
            shiftData_d = '0;
            frameDone_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            loadCnt_q   <= '0;
            latchPh_q   <= 1'b0;
            rowSel_q    <= '0;
            shiftEn_q   <= 1'b0;
            shiftData_q <= '0;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            loadCnt_q   <= loadCnt_d;
            latchPh_q   <= latchPh_d;
            rowSel_q    <= rowSel_d;
            shiftEn_q   <= shiftEn_d;
            shiftData_q <= shiftData_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign data_ready_o = (state_q == LOAD);
    assign shift_en_o   = shiftEn_q;
    assign shift_data_o = shiftData_q;
    assign hsync_o      = (state_q == LATCH) && latchPh_q;
    assign pwm_en_o     = (state_q == RUN);
    assign gcount_o     = gcount;
    assign row_sel_o    = rowSel_q;
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = frameDone_q;

endmodule

// File: tb/tb_pwm_scan_ctrl.sv
// Self-checking bench for pwm_scan_ctrl (DWIDTH=4, STAGE=4, ROWS=2 plus a ROWS=1 build).
module tb_pwm_scan_ctrl;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst, start, stop, dataValid;
    logic [DW-1:0] dataIn;
    logic          dataReady, shiftEn, hsync, pwmEn, busy, frameDone;
    logic [DW-1:0] shiftData, gcount;
    logic          rowSel;

    logic          start1, stop1, valid1;
    logic          r1Ready, r1ShiftEn, r1Hsync, r1PwmEn, r1Busy, r1Done;
    logic [DW-1:0] r1ShiftData, r1Gcount;
    logic          r1RowSel;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic          throttle = 1'b0;
    logic [DW-1:0] wordQ[$];
    logic [DW-1:0] expQ[$];

    always #5 clk = ~clk;

    pwm_scan_ctrl #(.DWIDTH(DW), .STAGE(4), .ROWS(2)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
        .data_in_i(dataIn), .data_valid_i(dataValid), .data_ready_o(dataReady),
        .shift_en_o(shiftEn), .shift_data_o(shiftData), .hsync_o(hsync),
        .pwm_en_o(pwmEn), .gcount_o(gcount), .row_sel_o(rowSel),
        .busy_o(busy), .frame_done_o(frameDone)
    );

    pwm_scan_ctrl #(.DWIDTH(DW), .STAGE(4), .ROWS(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .stop_i(stop1),
        .data_in_i(dataIn), .data_valid_i(valid1), .data_ready_o(r1Ready),
        .shift_en_o(r1ShiftEn), .shift_data_o(r1ShiftData), .hsync_o(r1Hsync),
        .pwm_en_o(r1PwmEn), .gcount_o(r1Gcount), .row_sel_o(r1RowSel),
        .busy_o(r1Busy), .frame_done_o(r1Done)
    );

    // Source model: words handed over on a handshake go to the scoreboard queue,
    // then the bench advances to the next falling edge and presents the next offer.
    task automatic cycle();
        if (dataValid && dataReady && !stop && !rst) begin
            expQ.push_back(dataIn);
            void'(wordQ.pop_front());
        end
        @(negedge clk);
        cyc++;
        dataIn    = (wordQ.size() > 0) ? wordQ[0] : '0;
        dataValid = (wordQ.size() > 0) && (throttle ? !dataValid : 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; start1 = 1'b1; dataValid = 1'b1; dataIn = 4'h5;
        cycle();
        cycle();
        checks++;
        if ({busy, dataReady, shiftEn, hsync, pwmEn, frameDone, gcount, rowSel, shiftData} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b want 0",
                     {busy, dataReady, shiftEn, hsync, pwmEn, frameDone, gcount, rowSel, shiftData});
        end
        checks++;
        if ({r1Busy, r1Ready, r1ShiftEn, r1Hsync, r1PwmEn, r1Done, r1Gcount, r1RowSel, r1ShiftData} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs_rows1 got %b want 0",
                     {r1Busy, r1Ready, r1ShiftEn, r1Hsync, r1PwmEn, r1Done, r1Gcount, r1RowSel, r1ShiftData});
        end
        start = 1'b0; start1 = 1'b0; rst = 1'b0;
        cycle();
        checks++;
        if (busy !== 1'b0 || r1Busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release busy=%b/%b want 0/0", busy, r1Busy);
        end
    endtask

    task automatic test_normal_frame();
        int shifts, lastShift;
        bit seen, consec;
        throttle = 1'b0;
        expQ.delete();
        wordQ = '{4'd3, 4'd7, 4'd0, 4'd15, 4'd9, 4'd1, 4'd12, 4'd6};
        start = 1'b1;
        cycle();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || dataReady !== 1'b1 || rowSel !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_entry busy=%b ready=%b row=%b want 1 1 0", busy, dataReady, rowSel);
        end
        for (int row = 0; row < 2; row++) begin
            shifts = 0; lastShift = -10; seen = 1'b0; consec = 1'b1;
            for (int k = 0; k < 40 && !seen; k++) begin
                cycle();
                if (shiftEn) begin
                    checks++;
                    if (expQ.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL shift_word row%0d got %0d want no shift", row, shiftData);
                    end else begin
                        if (shiftData !== expQ[0]) begin
                            errors++;
                            $display("[TB] FAIL shift_word row%0d got %0d want %0d", row, shiftData, expQ[0]);
                        end
                        void'(expQ.pop_front());
                    end
                    if (shifts > 0 && cyc != lastShift + 1) consec = 1'b0;
                    shifts++;
                    lastShift = cyc;
                end
                if (hsync) begin
                    seen = 1'b1;
                    checks++;
                    if (shiftEn || shifts != 4 || cyc != lastShift + 1 || !consec) begin
                        errors++;
                        $display("[TB] FAIL hsync_timing row%0d got shifts=%0d gap=%0d consec=%0b shiftEn=%b want 4 1 1 0",
                                 row, shifts, cyc - lastShift, consec, shiftEn);
                    end
                end
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("[TB] FAIL hsync_timeout row%0d got none want hsync", row);
            end
            for (int k = 0; k < 16; k++) begin
                cycle();
                checks++;
                if (pwmEn !== 1'b1 || gcount !== k[3:0] || rowSel !== row[0] || hsync || shiftEn || busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL run row%0d got pwm=%b gcount=%0d row=%b want 1 %0d %0d",
                             row, pwmEn, gcount, rowSel, k, row);
                end
            end
            cycle();
            checks++;
            if (row == 0) begin
                if ({pwmEn, gcount, busy, frameDone} !== {1'b0, 4'd0, 1'b1, 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL blank got pwm=%b gcount=%0d busy=%b done=%b want 0 0 1 0",
                             pwmEn, gcount, busy, frameDone);
                end
            end else begin
                if ({pwmEn, gcount, busy, frameDone} !== {1'b0, 4'd0, 1'b0, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL frame_end got pwm=%b gcount=%0d busy=%b done=%b want 0 0 0 1",
                             pwmEn, gcount, busy, frameDone);
                end
            end
        end
        cycle();
        checks++;
        if (frameDone !== 1'b0 || busy !== 1'b0 || shiftEn !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame_done_single got done=%b busy=%b want 0 0", frameDone, busy);
        end
    endtask

    task automatic test_throttled();
        int shifts, lastShift;
        bit seen, gapOk;
        throttle = 1'b1;
        expQ.delete();
        wordQ = '{4'd4, 4'd11, 4'd2, 4'd8};
        start = 1'b1;
        cycle();
        start = 1'b0;
        shifts = 0; lastShift = -10; seen = 1'b0; gapOk = 1'b1;
        for (int k = 0; k < 40 && !seen; k++) begin
            cycle();
            if (shiftEn) begin
                checks++;
                if (expQ.size() == 0 || shiftData !== expQ[0]) begin
                    errors++;
                    $display("[TB] FAIL throttled_word got %0d want %0d", shiftData,
                             (expQ.size() > 0) ? expQ[0] : 4'd0);
                end
                if (expQ.size() > 0) void'(expQ.pop_front());
                if (shifts > 0 && cyc != lastShift + 2) gapOk = 1'b0;
                shifts++;
                lastShift = cyc;
            end
            if (hsync) seen = 1'b1;
        end
        checks++;
        if (!seen || shifts != 4 || cyc != lastShift + 1 || !gapOk) begin
            errors++;
            $display("[TB] FAIL throttled_hsync got seen=%b shifts=%0d gap=%0d gapOk=%b want 1 4 1 1",
                     seen, shifts, cyc - lastShift, gapOk);
        end
        throttle = 1'b0;
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        checks++;
        if ({busy, pwmEn, hsync, gcount} !== '0) begin
            errors++;
            $display("[TB] FAIL stop_latch got busy=%b pwm=%b hsync=%b gcount=%0d want 0", busy, pwmEn, hsync, gcount);
        end
    endtask

    task automatic test_stop_run();
        bit seen, bad;
        expQ.delete();
        wordQ = '{4'd1, 4'd2, 4'd3, 4'd4};
        start = 1'b1;
        cycle();
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            cycle();
            if (hsync) seen = 1'b1;
        end
        for (int k = 0; k < 10; k++) cycle();
        checks++;
        if (!seen || gcount !== 4'd9 || pwmEn !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stop_run_setup got hsync=%b gcount=%0d pwm=%b want 1 9 1", seen, gcount, pwmEn);
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        checks++;
        if ({pwmEn, gcount, rowSel, busy, frameDone, hsync, shiftData} !== '0) begin
            errors++;
            $display("[TB] FAIL stop_run_idle got %b want 0", {pwmEn, gcount, rowSel, busy, frameDone, hsync, shiftData});
        end
        bad = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (hsync || frameDone || busy || pwmEn) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL stop_run_quiet got activity=1 want 0");
        end
    endtask

    task automatic test_stop_load();
        int shifts;
        bit seen, bad;
        expQ.delete();
        wordQ = '{4'd5, 4'd6, 4'd7, 4'd8};
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        checks++;
        if (shiftEn !== 1'b1 || shiftData !== 4'd6) begin
            errors++;
            $display("[TB] FAIL stop_load_setup got en=%b data=%0d want 1 6", shiftEn, shiftData);
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        checks++;
        if ({busy, dataReady, shiftEn, hsync, pwmEn, gcount, rowSel, shiftData} !== '0) begin
            errors++;
            $display("[TB] FAIL stop_load_idle got %b want 0", {busy, dataReady, shiftEn, hsync, pwmEn, gcount, rowSel, shiftData});
        end
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (hsync || shiftEn || busy) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL stop_load_quiet got activity=1 want 0");
        end
        wordQ = '{4'd10, 4'd11, 4'd12, 4'd13};
        expQ.delete();
        start = 1'b1;
        cycle();
        start = 1'b0;
        shifts = 0; seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            cycle();
            if (shiftEn) begin
                checks++;
                if (expQ.size() == 0 || shiftData !== expQ[0]) begin
                    errors++;
                    $display("[TB] FAIL reload_word got %0d want %0d", shiftData, (expQ.size() > 0) ? expQ[0] : 4'd0);
                end
                if (expQ.size() > 0) void'(expQ.pop_front());
                shifts++;
            end
            if (hsync) seen = 1'b1;
        end
        checks++;
        if (!seen || shifts != 4 || rowSel !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reload_row got hsync=%b shifts=%0d row=%b want 1 4 0", seen, shifts, rowSel);
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic test_start_busy();
        int dones;
        bit seen;
        expQ.delete();
        wordQ = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        start = 1'b1;
        cycle();
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 120 && !seen; k++) begin
            cycle();
            if (rowSel === 1'b1 && pwmEn === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL start_busy_reach got row1 run=0 want 1");
        end
        start = 1'b1;
        cycle();
        start = 1'b0;
        dones = 0;
        for (int k = 0; k < 60; k++) begin
            cycle();
            if (frameDone) dones++;
        end
        checks++;
        if (dones != 1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_busy got dones=%0d busy=%b want 1 0", dones, busy);
        end
    endtask

    task automatic test_reset_latch();
        bit seen;
        expQ.delete();
        wordQ = '{4'd9, 4'd10, 4'd11, 4'd12};
        start = 1'b1;
        cycle();
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            cycle();
            if (hsync) seen = 1'b1;
        end
        rst = 1'b1;
        cycle();
        checks++;
        if (!seen || {busy, dataReady, shiftEn, hsync, pwmEn, frameDone, gcount, rowSel, shiftData} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_latch got hsync_seen=%b outs=%b want 1 0", seen,
                     {busy, dataReady, shiftEn, hsync, pwmEn, frameDone, gcount, rowSel, shiftData});
        end
        rst = 1'b0;
        cycle();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_latch_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_rows1();
        int shifts;
        bit seen;
        throttle = 1'b0;
        wordQ = '{4'hA};
        cycle();
        start1 = 1'b1;
        cycle();
        start1 = 1'b0;
        shifts = 0; seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            cycle();
            if (r1ShiftEn) begin
                shifts++;
                checks++;
                if (r1ShiftData !== 4'hA) begin
                    errors++;
                    $display("[TB] FAIL rows1_word got %0d want 10", r1ShiftData);
                end
            end
            if (r1Hsync) seen = 1'b1;
        end
        checks++;
        if (!seen || shifts != 4) begin
            errors++;
            $display("[TB] FAIL rows1_load got hsync=%b shifts=%0d want 1 4", seen, shifts);
        end
        for (int k = 0; k < 16; k++) begin
            cycle();
            checks++;
            if (r1PwmEn !== 1'b1 || r1Gcount !== k[3:0] || r1RowSel !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rows1_run got pwm=%b gcount=%0d row=%b want 1 %0d 0", r1PwmEn, r1Gcount, r1RowSel, k);
            end
        end
        cycle();
        checks++;
        if ({r1Done, r1Busy, r1PwmEn, r1Gcount} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("[TB] FAIL rows1_end got done=%b busy=%b pwm=%b gcount=%0d want 1 0 0 0",
                     r1Done, r1Busy, r1PwmEn, r1Gcount);
        end
        cycle();
        checks++;
        if (r1Done !== 1'b0 || r1Busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rows1_after got done=%b busy=%b want 0 0", r1Done, r1Busy);
        end
        wordQ.delete();
    endtask

    // Runs every scenario in order and reports the totals.
    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; dataValid = 1'b0; dataIn = '0;
        start1 = 1'b0; stop1 = 1'b0; valid1 = 1'b1;
        test_reset();
        test_normal_frame();
        test_throttled();
        test_stop_run();
        test_stop_load();
        test_start_busy();
        test_reset_latch();
        test_rows1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guards against a stuck scenario so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
